int_ctrl_nch: RTL and testbench

//  Parametrised N-channel interrupt controller; successor to the CPU top's single raw int_sig input.

---
 rtl/int_ctrl_nch.sv | 115 +++++++++++
 tb/tb_int_ctrl_nch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_nch.sv
// N-channel interrupt controller: sync, latch, mask, fixed-priority grant, req/ack/rti handshake.
// Latency: source sampled at edge k -> pending k+3 -> irq_req k+4; irq_req holds until irq_ack.
module int_ctrl_nch #(
  parameter int                N_IRQ     = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] VEC_BASE  = 'h01,
  parameter logic [N_IRQ-1:0]  TRIG_EDGE = {N_IRQ{1'b1}},
  parameter logic [N_IRQ-1:0]  MASK_RST  = {N_IRQ{1'b0}},
  localparam int               ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_wdata,
  input  logic              irq_ack,
  input  logic              rti,
  output logic              irq_req,
  output logic [DATA_W-1:0] irq_vec,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_IRQ-1:0]  pending,
  output logic [N_IRQ-1:0]  mask,
  output logic              in_service
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  state_t              r_state;
  logic [N_IRQ-1:0]    r_meta, r_sync, r_s, r_prev, r_pend, r_mask;
  logic                r_req, r_svc;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_vec;

  logic [N_IRQ-1:0]    w_elig, w_rise, w_clr, w_pend_nxt;
  logic [ID_W-1:0]     w_win;
  logic                w_any, w_ack;

  assign w_elig = r_pend & ~r_mask;
  assign w_rise = r_s & ~r_prev;
  assign w_any  = |w_elig;
  assign w_ack  = (r_state == S_REQ) && irq_ack;

  always_comb begin
    w_win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  // Edge channels: a new edge beats a same-cycle ack clear. Level channels follow the synced source.
  always_comb begin
    w_clr      = '0;
    w_pend_nxt = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clr[i]      = w_ack && (r_id == ID_W'(i));
      w_pend_nxt[i] = TRIG_EDGE[i] ? (w_rise[i] | (r_pend[i] & ~w_clr[i])) : r_s[i];
    end
  end

  // r_s re-registers the synchroniser output so edge and level paths share one timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_s    <= '0;
      r_prev <= '0;
      r_pend <= '0;
      r_mask <= MASK_RST;
    end else begin
      r_meta <= irq_in;
      r_sync <= r_meta;
      r_s    <= r_sync;
      r_prev <= r_s;
      r_pend <= w_pend_nxt;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_svc   <= 1'b0;
      r_id    <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_id    <= w_win;
          r_vec   <= VEC_BASE + DATA_W'(w_win);
        end
        S_REQ: if (irq_ack) begin
          r_state <= S_SVC;
          r_req   <= 1'b0;
          r_svc   <= 1'b1;
        end
        S_SVC: if (rti) begin
          r_state <= S_IDLE;
          r_svc   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq_req    = r_req;
  assign irq_vec    = r_vec;
  assign irq_id     = r_id;
  assign pending    = r_pend;
  assign mask       = r_mask;
  assign in_service = r_svc;

endmodule

// File: tb/tb_int_ctrl_nch.sv
// Bench for int_ctrl_nch: an all-edge instance (a) and one with channel 0 level-triggered (b).
module tb_int_ctrl_nch;

  typedef struct {
    int id;
    int vec;
    int cyc;
  } exp_t;

  logic       clk, rst;
  logic [3:0] a_in, a_mwd, a_pend, a_mask;
  logic       a_mwe, a_ack, a_rti, a_req, a_svc;
  logic [7:0] a_vec;
  logic [1:0] a_id;
  logic [3:0] b_in, b_mwd, b_pend, b_mask;
  logic       b_mwe, b_ack, b_rti, b_req, b_svc;
  logic [7:0] b_vec;
  logic [1:0] b_id;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic a_req_q = 1'b0;
  logic b_req_q = 1'b0;

  int_ctrl_nch dut_a (
    .clk(clk), .rst(rst), .irq_in(a_in), .mask_we(a_mwe), .mask_wdata(a_mwd),
    .irq_ack(a_ack), .rti(a_rti), .irq_req(a_req), .irq_vec(a_vec), .irq_id(a_id),
    .pending(a_pend), .mask(a_mask), .in_service(a_svc)
  );

  int_ctrl_nch #(.TRIG_EDGE(4'b1110)) dut_b (
    .clk(clk), .rst(rst), .irq_in(b_in), .mask_we(b_mwe), .mask_wdata(b_mwd),
    .irq_ack(b_ack), .rti(b_rti), .irq_req(b_req), .irq_vec(b_vec), .irq_id(b_id),
    .pending(b_pend), .mask(b_mask), .in_service(b_svc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request monitors: every rising irq_req must match the oldest queued expectation.
  always @(negedge clk) begin
    if (a_req && !a_req_q) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_req: got id %0d required no request (cycle %0d)", a_id, cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_req_cycle", cyc, e.cyc);
        chk("a_irq_id", a_id, e.id);
        chk("a_irq_vec", a_vec, e.vec);
      end
    end
    a_req_q = a_req;
  end

  always @(negedge clk) begin
    if (b_req && !b_req_q) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_req: got id %0d required no request (cycle %0d)", b_id, cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_req_cycle", cyc, e.cyc);
        chk("b_irq_id", b_id, e.id);
        chk("b_irq_vec", b_vec, e.vec);
      end
    end
    b_req_q = b_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_a_ack;
    a_ack = 1'b1; tick(1); a_ack = 1'b0;
  endtask

  task automatic pulse_a_rti;
    a_rti = 1'b1; tick(1); a_rti = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0; a_mwe = 1'b0; a_mwd = '0; a_ack = 1'b0; a_rti = 1'b0;
    b_in = '0; b_mwe = 1'b0; b_mwd = '0; b_ack = 1'b0; b_rti = 1'b0;
    tick(3);
    chk("rst_req", a_req, 0);
    chk("rst_pending", a_pend, 0);
    chk("rst_mask", a_mask, 0);
    chk("rst_in_service", a_svc, 0);
    chk("rst_vec", a_vec, 0);
    rst = 1'b0;
    tick(2);

    // T1: ch2 edge -> vec 3, ack, rti
    a_in = 4'b0100;
    qa.push_back('{id: 2, vec: 8'h03, cyc: cyc + 5});
    tick(5);
    chk("t1_req_up", a_req, 1);
    chk("t1_pending", a_pend, 4'b0100);
    pulse_a_ack();
    chk("t1_in_service", a_svc, 1);
    chk("t1_pending_clr", a_pend, 0);
    chk("t1_req_drop", a_req, 0);
    a_in = '0;
    tick(2);
    pulse_a_rti();
    chk("t1_rti", a_svc, 0);
    tick(6);

    // T2: ch1 and ch3 together, ch1 first, ch3 the cycle after rti
    a_in = 4'b1010;
    qa.push_back('{id: 1, vec: 8'h02, cyc: cyc + 5});
    tick(5);
    pulse_a_ack();
    chk("t2_pending_left", a_pend, 4'b1000);
    tick(2);
    qa.push_back('{id: 3, vec: 8'h04, cyc: cyc + 2});
    pulse_a_rti();
    tick(1);
    chk("t2_rereq", a_req, 1);
    pulse_a_ack();
    pulse_a_rti();
    a_in = '0;
    tick(6);

    // T3: masked ch0 latches but does not request until unmasked
    a_mwe = 1'b1; a_mwd = 4'b0001; tick(1); a_mwe = 1'b0;
    chk("t3_mask", a_mask, 4'b0001);
    a_in = 4'b0001;
    tick(6);
    chk("t3_pending_masked", a_pend, 4'b0001);
    chk("t3_no_req", a_req, 0);
    a_mwe = 1'b1; a_mwd = 4'b0000;
    qa.push_back('{id: 0, vec: 8'h01, cyc: cyc + 2});
    tick(1); a_mwe = 1'b0;
    chk("t3_req_not_yet", a_req, 0);
    tick(1);

    // T4: new ch1 event during service of ch0 waits for rti
    pulse_a_ack();
    chk("t4_in_service", a_svc, 1);
    a_in = 4'b0011;
    tick(8);
    chk("t4_no_nesting", a_req, 0);
    chk("t4_pending", a_pend, 4'b0010);
    qa.push_back('{id: 1, vec: 8'h02, cyc: cyc + 2});
    pulse_a_rti();
    tick(1);

    // T5: grant frozen against mask change, then async reset mid-request
    a_mwe = 1'b1; a_mwd = 4'b1000; tick(1); a_mwe = 1'b0;
    chk("t5_frozen_req", a_req, 1);
    chk("t5_frozen_id", a_id, 1);
    chk("t5_mask_written", a_mask, 4'b1000);
    #2;
    rst = 1'b1;
    a_in = '0;
    #1;
    chk("t5_async_req", a_req, 0);
    chk("t5_async_pending", a_pend, 0);
    chk("t5_async_mask", a_mask, 0);
    chk("t5_async_svc", a_svc, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_a_ack();
    chk("t5_late_ack_req", a_req, 0);
    chk("t5_late_ack_svc", b_svc | a_svc, 0);
    tick(6);
    chk("t5_idle_after", a_req, 0);

    // T6: level ch0 on dut_b re-requests after rti while held, then clears
    b_in = 4'b0001;
    qb.push_back('{id: 0, vec: 8'h01, cyc: cyc + 5});
    tick(5);
    b_ack = 1'b1; tick(1); b_ack = 1'b0;
    chk("t6_in_service", b_svc, 1);
    chk("t6_level_kept", b_pend, 4'b0001);
    tick(2);
    qb.push_back('{id: 0, vec: 8'h01, cyc: cyc + 2});
    b_rti = 1'b1; tick(1); b_rti = 1'b0;
    tick(1);
    chk("t6_rereq", b_req, 1);
    b_ack = 1'b1; tick(1); b_ack = 1'b0;
    b_in = '0;
    tick(3);
    chk("t6_pending_hold", b_pend, 4'b0001);
    tick(1);
    chk("t6_pending_clear", b_pend, 0);
    b_rti = 1'b1; tick(1); b_rti = 1'b0;
    tick(4);
    chk("t6_idle_svc", b_svc, 0);
    chk("t6_idle_req", b_req, 0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
